// File: rtl/dlfloat_operand_loader.sv
// Byte-stream front end for the DLFloat16 MAC: assembles (a, b) operand pairs
// from four accepted bytes and queues them, with decoded flags, in a small FIFO.
module dlfloat_operand_loader #(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_in_byte,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_last,
    input  logic                   i_sync_clr,
    output logic [15:0]            o_pair_a,
    output logic [15:0]            o_pair_b,
    output logic                   o_pair_last,
    output logic                   o_pair_nan,
    output logic                   o_pair_zero,
    output logic                   o_pair_valid,
    input  logic                   i_pair_ready,
    output logic [$clog2(DEPTH):0] o_fill,
    output logic [15:0]            o_pair_cnt,
    output logic                   o_frame_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   L_FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_FILL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] L_PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {A_LO, A_HI, B_LO, B_HI} asm_state_t;

    asm_state_t    r_state;
    asm_state_t    w_state_nxt;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [15:0]   r_a;
    logic [7:0]    r_b_lo;
    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic [15:0]   r_pair_cnt;
    logic          r_frame_err;
    logic [32:0]   w_head;
    logic [15:0]   w_head_a;
    logic [15:0]   w_head_b;
    logic          w_head_nan;
    logic          w_head_zero;

    assign o_in_ready = (r_fill < L_FULL) && !i_sync_clr;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_push     = w_accept && (r_state == B_HI);
    assign w_valid    = (r_fill != '0);
    assign w_pop      = w_valid && i_pair_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= A_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_sync_clr) begin
            w_state_nxt = A_LO;
        end else if (w_accept) begin
            case (r_state)
                A_LO:    w_state_nxt = A_HI;
                A_HI:    w_state_nxt = B_LO;
                B_LO:    w_state_nxt = B_HI;
                default: w_state_nxt = A_LO;
            endcase
        end
    end

    // Partial operand bytes and FIFO storage carry data only, so they are not reset.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            case (r_state)
                A_LO:    r_a[7:0]  <= i_in_byte;
                A_HI:    r_a[15:8] <= i_in_byte;
                B_LO:    r_b_lo    <= i_in_byte;
                default: ;
            endcase
        end
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_last, r_a, i_in_byte, r_b_lo};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_pair_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + L_PTR_ONE;
                r_pair_cnt <= r_pair_cnt + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + L_FILL_ONE;
                2'b01:   r_fill <= r_fill - L_FILL_ONE;
                default: ;
            endcase
            // A marker on any byte but the last of a pair is a framing fault.
            if (w_accept && i_in_last && (r_state != B_HI)) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_a    = w_head[31:16];
    assign w_head_b    = w_head[15:0];
    assign w_head_nan  = (w_head_a == 16'hFFFF) || (w_head_b == 16'hFFFF);
    assign w_head_zero = (w_head_a == 16'h0000) || (w_head_b == 16'h0000);

    assign o_pair_valid = w_valid;
    assign o_pair_a     = w_valid ? w_head_a : 16'h0000;
    assign o_pair_b     = w_valid ? w_head_b : 16'h0000;
    assign o_pair_last  = w_valid && w_head[32];
    assign o_pair_nan   = w_valid && w_head_nan;
    assign o_pair_zero  = w_valid && w_head_zero && !w_head_nan;
    assign o_fill       = r_fill;
    assign o_pair_cnt   = r_pair_cnt;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Directed bench for dlfloat_operand_loader: pair assembly, flags, backpressure,
// abort, framing error and asynchronous reset, with hand-computed expectations.
module tb_dlfloat_operand_loader;
    logic        clk;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic        sync_clr;
    logic [15:0] pair_a;
    logic [15:0] pair_b;
    logic        pair_last;
    logic        pair_nan;
    logic        pair_zero;
    logic        pair_valid;
    logic        pair_ready;
    logic [2:0]  fill;
    logic [15:0] pair_cnt;
    logic        frame_err;

    int n_pass;
    int n_total;
    logic [15:0] popped[$];
    logic [15:0] exp_order[5];

    dlfloat_operand_loader #(.DEPTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_byte    (in_byte),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_last    (in_last),
        .i_sync_clr   (sync_clr),
        .o_pair_a     (pair_a),
        .o_pair_b     (pair_b),
        .o_pair_last  (pair_last),
        .o_pair_nan   (pair_nan),
        .o_pair_zero  (pair_zero),
        .o_pair_valid (pair_valid),
        .i_pair_ready (pair_ready),
        .o_fill       (fill),
        .o_pair_cnt   (pair_cnt),
        .o_frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic rdy);
        in_byte    = b;
        in_valid   = 1'b1;
        in_last    = last;
        pair_ready = rdy;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        pair_ready = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last,
                             input logic rdy_on_last);
        send_byte(a[7:0], 1'b0, 1'b0);
        send_byte(a[15:8], 1'b0, 1'b0);
        send_byte(b[7:0], 1'b0, 1'b0);
        send_byte(b[15:8], last, rdy_on_last);
    endtask

    task automatic pop_one();
        pair_ready = 1'b1;
        @(posedge clk); #1;
        pair_ready = 1'b0;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        in_byte    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        sync_clr   = 1'b0;
        pair_ready = 1'b0;
        exp_order  = '{16'h1514, 16'h1918, 16'h1D1C, 16'h2120, 16'h2524};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_valid", 32'(pair_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cnt", 32'(pair_cnt), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_pair_a", 32'(pair_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single pair
        send_pair(16'h3E00, 16'h4000, 1'b1, 1'b0);
        chk("p1_valid", 32'(pair_valid), 32'd1);
        chk("p1_a", 32'(pair_a), 32'h3E00);
        chk("p1_b", 32'(pair_b), 32'h4000);
        chk("p1_last", 32'(pair_last), 32'd1);
        chk("p1_nan", 32'(pair_nan), 32'd0);
        chk("p1_zero", 32'(pair_zero), 32'd0);
        chk("p1_fill", 32'(fill), 32'd1);
        pop_one();
        chk("p1_cnt", 32'(pair_cnt), 32'd1);
        chk("p1_valid_after", 32'(pair_valid), 32'd0);
        chk("p1_a_after", 32'(pair_a), 32'd0);
        chk("p1_b_after", 32'(pair_b), 32'd0);
        chk("p1_last_after", 32'(pair_last), 32'd0);

        // Fill to full, hold a byte, then drain while streaming
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0, 1'b0);
        chk("full_fill", 32'(fill), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_a", 32'(pair_a), 32'h1110);
        chk("full_head_b", 32'(pair_b), 32'h1312);
        in_byte  = 8'h20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("held_fill", 32'(fill), 32'd4);
        chk("held_in_ready", 32'(in_ready), 32'd0);
        pop_one();
        chk("pulse_fill", 32'(fill), 32'd3);
        chk("pulse_in_ready", 32'(in_ready), 32'd1);
        chk("pulse_head_a", 32'(pair_a), 32'h1514);
        chk("pulse_cnt", 32'(pair_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            if (pair_valid) popped.push_back(pair_a);
            send_byte(8'(8'h20 + i), 1'b0, 1'b1);
            chk("stream_fill_le4", 32'(fill <= 3'd4), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            if (pair_valid) popped.push_back(pair_a);
            pop_one();
        end
        chk("order_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < popped.size()) chk("order_a", 32'(popped[i]), 32'(exp_order[i]));
        end
        chk("stream_cnt", 32'(pair_cnt), 32'd7);
        chk("stream_fill", 32'(fill), 32'd0);

        // Flags, with same-cycle push/pop on the later pairs
        send_pair(16'hFFFF, 16'h1234, 1'b0, 1'b0);
        chk("f1_nan", 32'(pair_nan), 32'd1);
        chk("f1_zero", 32'(pair_zero), 32'd0);
        send_pair(16'h0000, 16'h5555, 1'b0, 1'b1);
        chk("f2_fill_pushpop", 32'(fill), 32'd1);
        chk("f2_a", 32'(pair_a), 32'h0000);
        chk("f2_b", 32'(pair_b), 32'h5555);
        chk("f2_zero", 32'(pair_zero), 32'd1);
        chk("f2_nan", 32'(pair_nan), 32'd0);
        chk("f2_cnt", 32'(pair_cnt), 32'd8);
        send_pair(16'h0000, 16'hFFFF, 1'b0, 1'b1);
        chk("f3_nan", 32'(pair_nan), 32'd1);
        chk("f3_zero", 32'(pair_zero), 32'd0);
        chk("f3_fill", 32'(fill), 32'd1);
        pop_one();
        chk("f_cnt", 32'(pair_cnt), 32'd10);
        chk("f_nan_empty", 32'(pair_nan), 32'd0);

        // Abort a partial pair
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        in_byte  = 8'hCC;
        in_valid = 1'b1;
        sync_clr = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sync_clr = 1'b0;
        chk("clr_fill", 32'(fill), 32'd0);
        send_pair(16'h2211, 16'h4433, 1'b0, 1'b0);
        chk("abort_fill", 32'(fill), 32'd1);
        chk("abort_a", 32'(pair_a), 32'h2211);
        chk("abort_b", 32'(pair_b), 32'h4433);
        chk("abort_frame_err", 32'(frame_err), 32'd0);
        pop_one();

        // Framing error
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        chk("fe_set", 32'(frame_err), 32'd1);
        chk("fe_fill", 32'(fill), 32'd1);
        chk("fe_a", 32'(pair_a), 32'h0201);
        chk("fe_b", 32'(pair_b), 32'h0403);
        chk("fe_last", 32'(pair_last), 32'd0);
        pop_one();
        chk("fe_cnt", 32'(pair_cnt), 32'd12);
        sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        chk("fe_sticky", 32'(frame_err), 32'd1);
        rst = 1'b1;
        #2;
        chk("fe_cleared", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset mid-frame with buffered data
        for (int k = 0; k < 5; k++) begin
            send_pair(16'(16'h0101 * (k + 1)), 16'h4000, 1'b0, 1'b0);
            pop_one();
        end
        send_pair(16'h1111, 16'h2222, 1'b0, 1'b0);
        send_pair(16'h3333, 16'h4444, 1'b1, 1'b0);
        send_byte(8'h99, 1'b0, 1'b0);
        send_byte(8'h88, 1'b0, 1'b0);
        chk("pre_fill", 32'(fill), 32'd2);
        chk("pre_cnt", 32'(pair_cnt), 32'd5);
        chk("pre_a", 32'(pair_a), 32'h0000 | 32'h1111);
        rst = 1'b1;
        #2;
        chk("arst_fill", 32'(fill), 32'd0);
        chk("arst_valid", 32'(pair_valid), 32'd0);
        chk("arst_cnt", 32'(pair_cnt), 32'd0);
        chk("arst_a", 32'(pair_a), 32'd0);
        chk("arst_b", 32'(pair_b), 32'd0);
        chk("arst_last", 32'(pair_last), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_pair(16'h3C5A, 16'h6677, 1'b0, 1'b0);
        chk("post_fill", 32'(fill), 32'd1);
        chk("post_a", 32'(pair_a), 32'h3C5A);
        chk("post_b", 32'(pair_b), 32'h6677);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
